// File: rtl/acc_cali_pulse_gen_if.sv
// Bundled run control, per-channel configuration and per-channel status of the
// calibration pulse generator; the master side drives configuration.
interface acc_cali_pulse_gen_if #(
  parameter int CH_NUM      = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int BURST_WIDTH = 16
);
  logic                          laser_start_i;
  logic [CH_NUM-1:0]             acc_cali_mode_i;
  logic [CH_NUM*CNT_WIDTH-1:0]   acc_cali_low_i;
  logic [CH_NUM*CNT_WIDTH-1:0]   acc_cali_high_i;
  logic [CH_NUM*BURST_WIDTH-1:0] acc_cali_burst_i;
  logic [CH_NUM-1:0]             acc_cali_ctrl_o;
  logic [CH_NUM-1:0]             acc_cali_busy_o;
  logic [CH_NUM-1:0]             acc_cali_done_o;
  logic [CH_NUM*BURST_WIDTH-1:0] acc_cali_cnt_o;

  modport master (
    output laser_start_i,
    output acc_cali_mode_i,
    output acc_cali_low_i,
    output acc_cali_high_i,
    output acc_cali_burst_i,
    input  acc_cali_ctrl_o,
    input  acc_cali_busy_o,
    input  acc_cali_done_o,
    input  acc_cali_cnt_o
  );

  modport slave (
    input  laser_start_i,
    input  acc_cali_mode_i,
    input  acc_cali_low_i,
    input  acc_cali_high_i,
    input  acc_cali_burst_i,
    output acc_cali_ctrl_o,
    output acc_cali_busy_o,
    output acc_cali_done_o,
    output acc_cali_cnt_o
  );
endinterface

// File: rtl/acc_cali_pulse_gen.sv
// Multi-channel calibration pulse generator: each channel plays a burst (or an
// endless train) of high pulses with programmable low/high phase lengths.
module acc_cali_pulse_gen #(
  parameter real TCQ         = 0.1,
  parameter int  CH_NUM      = 4,
  parameter int  CNT_WIDTH   = 32,
  parameter int  BURST_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  acc_cali_pulse_gen_if.slave cali_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if (CH_NUM < 1 || CH_NUM > 16 || TCQ < 0.0) begin : g_bad_param
    $error("acc_cali_pulse_gen: CH_NUM must be 1..16 and TCQ non-negative");
  end

  logic                          start_prev_q;
  logic                          start_evt;
  logic [CH_NUM-1:0]             ctrl_all;
  logic [CH_NUM-1:0]             busy_all;
  logic [CH_NUM-1:0]             done_all;
  logic [CH_NUM*BURST_WIDTH-1:0] cnt_all;

  // A start is a 0->1 transition of laser_start between consecutive edges.
  assign start_evt = cali_if.laser_start_i & ~start_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_prev_q <= 1'b0;
    end else begin
      start_prev_q <= cali_if.laser_start_i;
    end
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   phase_q, phase_d;
    logic [CNT_WIDTH-1:0]   low_q, low_d;
    logic [CNT_WIDTH-1:0]   high_q, high_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
    logic [BURST_WIDTH-1:0] cnt_inc;
    logic                   ctrl_q, ctrl_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   run_ok;

    assign run_ok  = cali_if.laser_start_i & cali_if.acc_cali_mode_i[n];
    assign cnt_inc = cnt_q + BURST_WIDTH'(1);

    // Abort wins over everything; otherwise a start reloads the shadows, and
    // only then does the phase sequencing of the running channel advance.
    always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      low_d   = low_q;
      high_d  = high_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (!run_ok) begin
        state_d = S_IDLE;
      end else if (start_evt) begin
        low_d   = cali_if.acc_cali_low_i[n*CNT_WIDTH +: CNT_WIDTH];
        high_d  = cali_if.acc_cali_high_i[n*CNT_WIDTH +: CNT_WIDTH];
        burst_d = cali_if.acc_cali_burst_i[n*BURST_WIDTH +: BURST_WIDTH];
        phase_d = '0;
        cnt_d   = '0;
        state_d = S_LOW;
      end else begin
        case (state_q)
          S_LOW: begin
            if (phase_q == low_q) begin
              phase_d = '0;
              state_d = S_HIGH;
            end else begin
              phase_d = phase_q + CNT_WIDTH'(1);
            end
          end
          S_HIGH: begin
            if (phase_q == high_q) begin
              phase_d = '0;
              cnt_d   = cnt_inc;
              if (burst_q != '0 && cnt_inc == burst_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_LOW;
              end
            end else begin
              phase_d = phase_q + CNT_WIDTH'(1);
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
      ctrl_d = (state_d == S_HIGH);
      busy_d = (state_d == S_LOW) || (state_d == S_HIGH);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= S_IDLE;
        phase_q <= '0;
        low_q   <= '0;
        high_q  <= '0;
        burst_q <= '0;
        cnt_q   <= '0;
        ctrl_q  <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        phase_q <= phase_d;
        low_q   <= low_d;
        high_q  <= high_d;
        burst_q <= burst_d;
        cnt_q   <= cnt_d;
        ctrl_q  <= ctrl_d;
        busy_q  <= busy_d;
        done_q  <= done_d;
      end
    end

    assign ctrl_all[n] = ctrl_q;
    assign busy_all[n] = busy_q;
    assign done_all[n] = done_q;
    assign cnt_all[n*BURST_WIDTH +: BURST_WIDTH] = cnt_q;
  end

  assign cali_if.acc_cali_ctrl_o = ctrl_all;
  assign cali_if.acc_cali_busy_o = busy_all;
  assign cali_if.acc_cali_done_o = done_all;
  assign cali_if.acc_cali_cnt_o  = cnt_all;

endmodule

// File: tb/tb_acc_cali_pulse_gen.sv
// Self-checking bench for acc_cali_pulse_gen: directed scenarios plus random
// configurations, compared every cycle against an arithmetic timing model.
module tb_acc_cali_pulse_gen;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acc_cali_pulse_gen_if #(.CH_NUM(CH), .CNT_WIDTH(CW), .BURST_WIDTH(BW)) cif ();

  acc_cali_pulse_gen #(.TCQ(0.1), .CH_NUM(CH), .CNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cali_if(cif)
  );

  int checks = 0;
  int errors = 0;

  // Model: a running channel is described by the cycles elapsed since its start.
  bit     mActive[CH];
  longint mK[CH];
  longint mL[CH], mH[CH], mB[CH];
  int     mHeld[CH];
  bit     mPrevLs;
  int     expCtrl[CH], expBusy[CH], expDone[CH], expCnt[CH];
  int     doneSeen[CH];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int n = 0; n < CH; n++) begin
      mActive[n] = 1'b0;
      mK[n] = 0;
      mHeld[n] = 0;
      expCtrl[n] = 0; expBusy[n] = 0; expDone[n] = 0; expCnt[n] = 0;
    end
    mPrevLs = 1'b0;
  endtask

  task automatic modelEdge();
    longint p;
    for (int n = 0; n < CH; n++) begin
      if (!cif.laser_start_i || !cif.acc_cali_mode_i[n]) begin
        mActive[n] = 1'b0;
      end else if (!mPrevLs) begin
        mActive[n] = 1'b1;
        mK[n] = 0;
        mL[n] = longint'(cif.acc_cali_low_i[n*CW +: CW]);
        mH[n] = longint'(cif.acc_cali_high_i[n*CW +: CW]);
        mB[n] = longint'(cif.acc_cali_burst_i[n*BW +: BW]);
        mHeld[n] = 0;
      end else if (mActive[n]) begin
        mK[n]++;
      end
      expDone[n] = 0;
      if (!mActive[n]) begin
        expCtrl[n] = 0; expBusy[n] = 0; expCnt[n] = mHeld[n];
      end else begin
        p = mL[n] + mH[n] + 2;
        if (mB[n] != 0 && mK[n] >= mB[n] * p) begin
          expCtrl[n] = 0; expBusy[n] = 0;
          expDone[n] = (mK[n] == mB[n] * p) ? 1 : 0;
          expCnt[n] = int'(mB[n]);
        end else begin
          expCtrl[n] = ((mK[n] % p) > mL[n]) ? 1 : 0;
          expBusy[n] = 1;
          expCnt[n] = int'((mK[n] / p) % (64'd1 << BW));
        end
        mHeld[n] = expCnt[n];
      end
    end
    mPrevLs = cif.laser_start_i;
  endtask

  task automatic checkAllChannels();
    for (int n = 0; n < CH; n++) begin
      checkOutput($sformatf("ctrl[%0d]", n), 32'(cif.acc_cali_ctrl_o[n]), 32'(expCtrl[n]));
      checkOutput($sformatf("busy[%0d]", n), 32'(cif.acc_cali_busy_o[n]), 32'(expBusy[n]));
      checkOutput($sformatf("done[%0d]", n), 32'(cif.acc_cali_done_o[n]), 32'(expDone[n]));
      checkOutput($sformatf("cnt[%0d]", n), 32'(cif.acc_cali_cnt_o[n*BW +: BW]), 32'(expCnt[n]));
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    for (int n = 0; n < CH; n++) doneSeen[n] += int'(cif.acc_cali_done_o[n]);
    checkAllChannels();
  endtask

  task automatic applyStimulus(input bit laser, input logic [CH-1:0] mode);
    cif.laser_start_i   = laser;
    cif.acc_cali_mode_i = mode;
  endtask

  task automatic setChannel(input int n, input int l, input int h, input int b);
    cif.acc_cali_low_i[n*CW +: CW]   = CW'(l);
    cif.acc_cali_high_i[n*CW +: CW]  = CW'(h);
    cif.acc_cali_burst_i[n*BW +: BW] = BW'(b);
  endtask

  task automatic stopAll();
    applyStimulus(1'b0, cif.acc_cali_mode_i);
    stepCycle();
    stepCycle();
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b0, '0);
    cif.acc_cali_low_i = '0;
    cif.acc_cali_high_i = '0;
    cif.acc_cali_burst_i = '0;
    for (int n = 0; n < CH; n++) doneSeen[n] = 0;
    modelReset();
    #1 rst = 1'b1;
    #2 checkAllChannels();
    @(negedge clk) rst = 1'b0;
    stepCycle();

    // Burst of two on channel 0 with L=2 H=1.
    setChannel(0, 2, 1, 2);
    applyStimulus(1'b1, 4'b0001);
    for (int i = 0; i < 14; i++) begin
      stepCycle();
      if (i == 3) checkOutput("req032_ctrl_e3", 32'(cif.acc_cali_ctrl_o[0]), 32'd1);
      if (i == 10) begin
        checkOutput("req032_done_e10", 32'(cif.acc_cali_done_o[0]), 32'd1);
        checkOutput("req032_cnt_e10", 32'(cif.acc_cali_cnt_o[0 +: BW]), 32'd2);
      end
    end
    stopAll();

    // Continuous toggle on channel 1 including count wrap.
    setChannel(1, 0, 0, 0);
    applyStimulus(1'b1, 4'b0010);
    for (int i = 0; i < 520; i++) begin
      stepCycle();
      if (i == 511) checkOutput("req033_cnt_ff", 32'(cif.acc_cali_cnt_o[BW +: BW]), 32'hFF);
      if (i == 512) checkOutput("req033_cnt_wrap", 32'(cif.acc_cali_cnt_o[BW +: BW]), 32'h0);
    end
    stopAll();

    // Laser drop during HIGH, then restart.
    setChannel(0, 3, 4, 0);
    applyStimulus(1'b1, 4'b0001);
    repeat (14) stepCycle();
    applyStimulus(1'b0, 4'b0001);
    stepCycle();
    checkOutput("req034_ctrl_drop", 32'(cif.acc_cali_ctrl_o[0]), 32'd0);
    checkOutput("req034_cnt_held", 32'(cif.acc_cali_cnt_o[0 +: BW]), 32'd1);
    applyStimulus(1'b1, 4'b0001);
    stepCycle();
    checkOutput("req034_cnt_restart", 32'(cif.acc_cali_cnt_o[0 +: BW]), 32'd0);
    // Mid-run reprogramming must not disturb the running channel.
    setChannel(0, 9, 9, 1);
    repeat (20) stepCycle();
    stopAll();

    // Four channels with distinct periods; channel 2 disabled mid-run.
    for (int n = 0; n < CH; n++) begin
      setChannel(n, 2 * n + 1, 1, 3);
      doneSeen[n] = 0;
    end
    applyStimulus(1'b1, 4'b1111);
    for (int i = 0; i < 40; i++) begin
      if (i == 10) applyStimulus(1'b1, 4'b1011);
      stepCycle();
    end
    checkOutput("req036_done0", 32'(doneSeen[0]), 32'd1);
    checkOutput("req036_done1", 32'(doneSeen[1]), 32'd1);
    checkOutput("req036_done2", 32'(doneSeen[2]), 32'd0);
    checkOutput("req036_done3", 32'(doneSeen[3]), 32'd1);
    stopAll();

    // Maximum phase lengths.
    setChannel(3, 255, 255, 1);
    applyStimulus(1'b1, 4'b1000);
    repeat (516) stepCycle();
    checkOutput("req029_cnt_max", 32'(cif.acc_cali_cnt_o[3*BW +: BW]), 32'd1);
    stopAll();

    // Random configurations with input churn and occasional mode drops.
    for (int it = 0; it < 16; it++) begin
      for (int n = 0; n < CH; n++)
        setChannel(n, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      applyStimulus(1'b1, CH'($urandom));
      for (int c = 0; c < int'($urandom_range(20, 60)); c++) begin
        stepCycle();
        if ($urandom_range(0, 7) == 0)
          setChannel(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
        if ($urandom_range(0, 19) == 0)
          applyStimulus(1'b1, cif.acc_cali_mode_i ^ CH'(1 << $urandom_range(0, CH - 1)));
      end
      stopAll();
    end

    // Asynchronous reset in the middle of a HIGH phase.
    setChannel(0, 0, 5, 0);
    applyStimulus(1'b1, 4'b0001);
    repeat (3) stepCycle();
    checkOutput("req037_in_high", 32'(cif.acc_cali_ctrl_o[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAllChannels();
    @(negedge clk) rst = 1'b0;
    stepCycle();
    checkOutput("req037_restart_busy", 32'(cif.acc_cali_busy_o[0]), 32'd1);
    repeat (10) stepCycle();
    stopAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/acc_cali_pulse_gen.md
ACC_CALI_PULSE_GEN -- requirements
Module: acc_cali_pulse_gen

Interface
REQ-001 Parameter TCQ, default 0.1, register clock-to-Q simulation delay.
REQ-002 Parameter CH_NUM, default 4, number of independent calibration channels (1..16).
REQ-003 Parameter CNT_WIDTH, default 32, width of low/high phase length fields.
REQ-004 Parameter BURST_WIDTH, default 16, width of burst length and pulse count fields.
REQ-005 clk_i  in  1  sole clock; all logic SHALL be in this domain.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 laser_start_i  in  1  run enable; its rising edge starts all enabled channels, its low level aborts all channels.
REQ-008 acc_cali_mode_i  in  CH_NUM  per-channel enable.
REQ-009 acc_cali_low_i  in  CH_NUM*CNT_WIDTH  per-channel low length L; channel n at bits [n*CNT_WIDTH +: CNT_WIDTH].
REQ-010 acc_cali_high_i  in  CH_NUM*CNT_WIDTH  per-channel high length H, same packing.
REQ-011 acc_cali_burst_i  in  CH_NUM*BURST_WIDTH  per-channel burst count B; 0 = continuous.
REQ-012 acc_cali_ctrl_o  out  CH_NUM  calibration control pulse per channel.
REQ-013 acc_cali_busy_o  out  CH_NUM  1 while channel in LOW or HIGH.
REQ-014 acc_cali_done_o  out  CH_NUM  one-cycle pulse on burst completion.
REQ-015 acc_cali_cnt_o  out  CH_NUM*BURST_WIDTH  per-channel completed high-phase count.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE, LOW, HIGH, DONE; all outputs registered.
REQ-017 A start event SHALL be a clock edge where laser_start_i samples 1 and its registered previous sample is 0.
REQ-018 On a start event, each channel with acc_cali_mode_i[n]=1 SHALL latch L, H, B into shadow registers, clear its phase counter and acc_cali_cnt_o, and enter LOW at that same edge; later input changes SHALL NOT affect the running sequence.
REQ-019 A channel enabled after the start event SHALL stay IDLE until the next start event.
REQ-020 LOW SHALL last exactly L+1 cycles (phase counter 0..L, transition on counter==L); L=0 gives 1 cycle.
REQ-021 HIGH SHALL last exactly H+1 cycles by the same rule; acc_cali_ctrl_o[n]=1 exactly while in HIGH.
REQ-022 On leaving HIGH, acc_cali_cnt_o[n] SHALL increment by 1, wrapping modulo 2^BURST_WIDTH.
REQ-023 With B=0, HIGH SHALL always return to LOW (continuous, period L+H+2).
REQ-024 With B>0, HIGH SHALL return to LOW until the B-th HIGH phase ends, then enter DONE with acc_cali_done_o[n]=1 for exactly that one cycle.
REQ-025 DONE SHALL hold ctrl_o=0, busy_o=0, cnt_o frozen, until laser_start_i falls or acc_cali_mode_i[n] falls, then IDLE.
REQ-026 laser_start_i sampled 0 SHALL force every channel to IDLE at that edge, ctrl_o/busy_o/done_o to 0; cnt_o SHALL hold its value.
REQ-027 acc_cali_mode_i[n] sampled 0 SHALL force channel n to IDLE at that edge with ctrl_o/busy_o/done_o = 0; other channels unaffected.
REQ-028 Abort (REQ-026/027) SHALL take priority over any same-edge phase transition, increment or done pulse.
REQ-029 Phase counters SHALL be CNT_WIDTH bits; L or H = 2^CNT_WIDTH-1 SHALL work without overflow.

Reset
REQ-030 rst_i=1 SHALL asynchronously set all FSMs to IDLE and all counters, shadows, outputs and the laser_start_i history register to 0.
REQ-031 If laser_start_i is 1 at first edge after rst_i release, that edge SHALL be a start event.

Verification
REQ-032 CH0 L=2 H=1 B=2, start at edge E0 -> ctrl_o[0] high E3-E4 and E8-E9, done_o[0] pulse at E10, cnt_o[0]=2, busy_o[0] high E0-E9.
REQ-033 CH1 L=0 H=0 B=0 -> ctrl_o[1] toggles every cycle indefinitely, cnt_o[1] increments every 2 cycles and wraps 0xFFFF->0.
REQ-034 CH0 running, laser_start_i dropped during HIGH -> ctrl_o[0]=0 next edge, no done pulse, cnt_o held; re-raise restarts from LOW with cnt_o=0.
REQ-035 Change acc_cali_low_i mid-run -> running period unchanged; new value used only after next start event.
REQ-036 Four channels L=1,3,5,7 H=1 B=3 simultaneously -> independent periods 4,6,8,10; each done_o pulses once at its own time; mode_i[2] cleared mid-run idles only channel 2.
REQ-037 rst_i asserted mid-HIGH -> all outputs 0 immediately (no clock needed); release with laser_start_i=1 -> restart at next edge.
